// File: rtl/led_bank_pkg.sv
// Shared types and defaults for the LED bank sequencer.
// Mode and FSM state encodings used by led_bank_ctrl.
package led_bank_pkg;

    localparam int NUM_LEDS_DEF = 8;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running period counter with synchronous clear.
// tc is high while the count equals the programmed period.
module led_prescaler
    import led_bank_pkg::*;
#(
    parameter int PeriodWidth = PERIOD_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr,
    input  logic [PeriodWidth-1:0] period,
    output logic                   tc
);

    logic [PeriodWidth-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PeriodWidth'(1);
        end
    end

    assign tc = (cnt == period);

endmodule

// File: rtl/led_bank_ctrl.sv
// Sequencer driving a bank of enable-flop LED cells with
// static, chasing and blinking patterns at a programmable rate.
module led_bank_ctrl
    import led_bank_pkg::*;
#(
    parameter int NumLeds     = NUM_LEDS_DEF,
    parameter int PeriodWidth = PERIOD_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [1:0]             cfg_mode_i,
    input  logic [NumLeds-1:0]     cfg_pattern_i,
    input  logic [PeriodWidth-1:0] cfg_period_i,
    output logic [NumLeds-1:0]     led_en_o,
    output logic [NumLeds-1:0]     led_d_o,
    input  logic [NumLeds-1:0]     led_q_i,
    output logic                   busy_o,
    output logic                   tick_o
);

    state_e                 state, state_n;
    mode_e                  mode_q;
    logic [NumLeds-1:0]     pattern_q;
    logic [PeriodWidth-1:0] period_q;
    logic                   xfer;
    logic                   tc;
    logic [NumLeds-1:0]     en_n, d_n, rot;
    logic                   tick_n;

    assign xfer = cfg_valid_i && cfg_ready_o;
    assign rot  = {led_q_i[NumLeds-2:0], led_q_i[NumLeds-1]};

    // Counter is held at zero outside RUN so each RUN starts from 0.
    led_prescaler #(
        .PeriodWidth(PeriodWidth)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr   (state != ST_RUN),
        .period(period_q),
        .tc    (tc)
    );

    always_comb begin
        state_n = state;
        en_n    = '0;
        d_n     = '0;
        tick_n  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (xfer) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (mode_q == MODE_CHASE || mode_q == MODE_BLINK)
                    state_n = ST_RUN;
                else
                    state_n = ST_IDLE;
            end
            ST_RUN: begin
                if (xfer)    state_n = ST_LOAD;
                else if (tc) state_n = ST_UPDATE;
            end
            ST_UPDATE: state_n = ST_RUN;
            default:   state_n = ST_IDLE;
        endcase

        // LOAD is only reachable through a transfer, so use live cfg inputs.
        if (state_n == ST_LOAD) begin
            en_n = '1;
            if (mode_e'(cfg_mode_i) != MODE_OFF) d_n = cfg_pattern_i;
        end else if (state_n == ST_UPDATE) begin
            en_n   = '1;
            tick_n = 1'b1;
            if (mode_q == MODE_CHASE) d_n = rot;
            else                      d_n = led_q_i ^ pattern_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_OFF;
            pattern_q   <= '0;
            period_q    <= '0;
            led_en_o    <= '0;
            led_d_o     <= '0;
            tick_o      <= 1'b0;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
        end else begin
            state       <= state_n;
            led_en_o    <= en_n;
            led_d_o     <= d_n;
            tick_o      <= tick_n;
            busy_o      <= (state_n != ST_IDLE);
            cfg_ready_o <= (state_n == ST_IDLE) || (state_n == ST_RUN);
            if (xfer) begin
                mode_q    <= mode_e'(cfg_mode_i);
                pattern_q <= cfg_pattern_i;
                period_q  <= cfg_period_i;
            end
        end
    end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Randomized and directed checks of led_bank_ctrl against a
// timeline model of the sequencer plus an LED cell bank model.
module tb_led_bank_ctrl;

    localparam int NL = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_mode = '0;
    logic [NL-1:0] cfg_pattern = '0;
    logic [PW-1:0] cfg_period = '0;
    logic [NL-1:0] led_en, led_d, cells;
    logic          busy, tick;
    logic          glitch = 1'b0;
    logic [NL-1:0] gval = '0;

    int checks = 0;
    int errors = 0;

    led_bank_ctrl #(.NumLeds(NL), .PeriodWidth(PW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_mode_i   (cfg_mode),
        .cfg_pattern_i(cfg_pattern),
        .cfg_period_i (cfg_period),
        .led_en_o     (led_en),
        .led_d_o      (led_d),
        .led_q_i      (cells),
        .busy_o       (busy),
        .tick_o       (tick)
    );

    always #5 clk = ~clk;

    // LED cell bank: DFF with reset and enable-hold mux per bit.
    always @(posedge clk) begin
        if (!rst_n)      cells <= '0;
        else if (glitch) cells <= gval;
        else             cells <= (cells & ~led_en) | (led_d & led_en);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: the cycle after the transfer edge is LOAD; after that,
    // CHASE/BLINK repeat (P+1) RUN cycles followed by one UPDATE cycle.
    longint        cyc = 0;
    longint        t0 = 0;
    bit            active = 0;
    bit            model_ok = 0;
    logic [1:0]    mmode = '0;
    logic [NL-1:0] mpat = '0;
    longint        mp = 0;
    logic [NL-1:0] exp_en = '0, exp_d = '0;
    logic          exp_tick = 0, exp_busy = 0, exp_ready = 1;

    always @(posedge clk) begin : model
        logic [NL-1:0] qs;
        longint dd, o;
        qs = cells;
        cyc++;
        if (!rst_n) begin
            active = 0;
            model_ok = 1;
        end else if (model_ok && cfg_valid && exp_ready) begin
            active = 1;
            t0 = cyc;
            mmode = cfg_mode;
            mpat = cfg_pattern;
            mp = longint'(cfg_period);
        end
        exp_en = '0; exp_d = '0; exp_tick = 0; exp_busy = 0; exp_ready = 1;
        if (active) begin
            dd = cyc - t0;
            if (dd == 0) begin
                exp_en = '1;
                exp_d = (mmode == 2'd0) ? '0 : mpat;
                exp_busy = 1;
                exp_ready = 0;
            end else if (mmode >= 2'd2) begin
                o = (dd - 1) % (mp + 2);
                exp_busy = 1;
                if (o == mp + 1) begin
                    exp_en = '1;
                    exp_tick = 1;
                    exp_ready = 0;
                    exp_d = (mmode == 2'd2) ? {qs[NL-2:0], qs[NL-1]} : (qs ^ mpat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("en", 32'(led_en), 32'(exp_en));
            chk("tick", 32'(tick), 32'(exp_tick));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("ready", 32'(cfg_ready), 32'(exp_ready));
            if (exp_en != '0) chk("d", 32'(led_d), 32'(exp_d));
        end
    end

    // Returns at the negedge of the LOAD cycle with valid dropped.
    task automatic send(input logic [1:0] m, input logic [NL-1:0] p, input logic [PW-1:0] per);
        int n = 0;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = m; cfg_pattern = p; cfg_period = per;
        while (cfg_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 200);
        if (n >= 200) chk("tick_timeout", 32'(n), 32'd0);
    endtask

    logic [NL-1:0] chase_exp [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        // Reset with valid held high: no transfer may be taken.
        cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_pattern = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(led_en), 32'h0);
        chk("rst_d", 32'(led_d), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        cfg_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cells", 32'(cells), 32'h0);

        // STATIC
        send(2'd1, 8'hA5, 16'd0);
        chk("static_en", 32'(led_en), 32'hFF);
        chk("static_d", 32'(led_d), 32'hA5);
        @(negedge clk);
        chk("static_busy", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);
        chk("static_hold", 32'(cells), 32'hA5);

        // CHASE 81, P=3
        send(2'd2, 8'h81, 16'd3);
        chk("chase_load", 32'(led_d), 32'h81);
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            chk("chase_gap", 32'(n), 32'd5);
            chk("chase_d", 32'(led_d), 32'(chase_exp[k]));
        end
        // OFF issued on the edge where counter==P: UPDATE skipped.
        repeat (4) @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_pattern = 8'hFF; cfg_period = '0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("reconf_en", 32'(led_en), 32'hFF);
        chk("reconf_d", 32'(led_d), 32'h00);
        chk("reconf_tick", 32'(tick), 32'h0);
        @(negedge clk);
        chk("reconf_idle", 32'(busy), 32'h0);

        // BLINK 0F, P=0
        send(2'd3, 8'h0F, 16'd0);
        chk("blink_load", 32'(led_d), 32'h0F);
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            chk("blink_gap", 32'(n), 32'd2);
            chk("blink_d", 32'(led_d), (k % 2 == 0) ? 32'h00 : 32'h0F);
        end

        // Valid held through LOAD is accepted in the first RUN cycle.
        send(2'd0, 8'h00, 16'd0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_pattern = 8'h55; cfg_period = 16'd5;
        @(negedge clk);
        chk("held_load1", 32'(led_d), 32'h55);
        cfg_mode = 2'd1; cfg_pattern = 8'h3C;
        @(negedge clk);
        chk("held_run_en", 32'(led_en), 32'h0);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("held_load2_en", 32'(led_en), 32'hFF);
        chk("held_load2_d", 32'(led_d), 32'h3C);

        // Reset asserted during UPDATE.
        send(2'd2, 8'h01, 16'd2);
        wait_tick(n);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_upd_en", 32'(led_en), 32'h0);
        chk("rst_upd_busy", 32'(busy), 32'h0);
        chk("rst_upd_ready", 32'(cfg_ready), 32'h1);

        // Randomized traffic including all-zero chase / all-one blink.
        for (int i = 0; i < 60; i++) begin
            int act;
            logic [NL-1:0] p;
            act = $urandom_range(0, 9);
            p = NL'($urandom);
            if ($urandom_range(0, 5) == 0) p = '0;
            if ($urandom_range(0, 5) == 0) p = '1;
            if (act < 8) begin
                send(2'($urandom_range(0, 3)), p, PW'($urandom_range(0, 6)));
            end else if (act == 8) begin
                @(negedge clk);
                glitch = 1'b1; gval = NL'($urandom);
                @(negedge clk);
                glitch = 1'b0;
            end else begin
                @(negedge clk);
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
